// File: rtl/interconnect_scheduler_pkg.sv
// Shared constants and types for the buffer-RAM slot scheduler.
// Default sizing plus the per-slot ownership state encoding.
package FHE_ALU_PKG;

  localparam int MODULE_NUM   = 4;
  localparam int SLOT_NUM     = 4;
  localparam int STAGE_MODULE = 2;
  localparam int SCHED_LEN_W  = 16;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_BUSY  = 2'd1,
    SLOT_DRAIN = 2'd2
  } slot_state_e;

endpackage

// File: rtl/interconnect_scheduler_slot_owner_fsm.sv
// Per-slot ownership FSM: round-robin pick among eligible modules, then holds
// the slot for the burst beats plus the interconnect drain.
module slot_owner_fsm
  import FHE_ALU_PKG::*;
#(
  parameter int N_MOD = 4,
  parameter int SW    = 2,
  parameter int STAGE = 2,
  parameter int LEN_W = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_MOD-1:0]            elig,
  input  logic [N_MOD-1:0][LEN_W-1:0] req_len,
  output logic                        grant_valid,
  output logic [SW-1:0]               grant_mod,
  output logic                        busy,
  output logic                        drain_last,
  output logic                        active,
  output logic [SW-1:0]               owner
);

  localparam int MW = (N_MOD > 1) ? $clog2(N_MOD) : 1;
  localparam logic [1:0] ST_IDLE  = 2'(SLOT_IDLE);
  localparam logic [1:0] ST_BUSY  = 2'(SLOT_BUSY);
  localparam logic [1:0] ST_DRAIN = 2'(SLOT_DRAIN);

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, win_len;
  logic [SW-1:0]    rr_q, rr_d, owner_q, owner_d;
  logic             free, hit;

  function automatic logic [MW-1:0] rr_index(input logic [SW-1:0] base, input int off);
    return MW'((int'(base) + off) % N_MOD);
  endfunction

  // The final drain cycle already counts as free so a waiting request wins the next cycle.
  assign busy       = (state_q == ST_BUSY);
  assign drain_last = (state_q == ST_DRAIN) && (cnt_q == LEN_W'(1));
  assign active     = busy || ((state_q == ST_DRAIN) && !drain_last);
  assign free       = (state_q == ST_IDLE) || drain_last;
  assign owner      = owner_q;

  // Round-robin search starting at rr_q with wrap-around
  always_comb begin
    grant_valid = 1'b0;
    grant_mod   = {SW{1'b0}};
    win_len     = {LEN_W{1'b0}};
    hit         = 1'b0;
    for (int i = 0; i < N_MOD; i++) begin
      hit         = free && !grant_valid && elig[rr_index(rr_q, i)];
      grant_mod   = hit ? SW'(rr_index(rr_q, i)) : grant_mod;
      win_len     = hit ? req_len[rr_index(rr_q, i)] : win_len;
      grant_valid = grant_valid || hit;
    end
  end

  // Next-state: count down beats, then drain; a grant overrides and restarts the burst
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_BUSY: begin
        if (cnt_q == LEN_W'(1)) begin
          state_d = ST_DRAIN;
          cnt_d   = LEN_W'(STAGE);
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_last) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant_valid) begin
      state_d = ST_BUSY;
      cnt_d   = (win_len == {LEN_W{1'b0}}) ? LEN_W'(1) : win_len;
      owner_d = grant_mod;
      rr_d    = (grant_mod == SW'(N_MOD - 1)) ? {SW{1'b0}} : grant_mod + SW'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= {LEN_W{1'b0}};
      rr_q    <= {SW{1'b0}};
      owner_q <= {SW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: rtl/interconnect_scheduler.sv
// Buffer-RAM slot scheduler: per-slot round-robin ownership driving the
// interconnect module_select / slot_select arrays.
module interconnect_scheduler #(
  parameter int MODULE_NUM   = FHE_ALU_PKG::MODULE_NUM,
  parameter int SLOT_NUM     = FHE_ALU_PKG::SLOT_NUM,
  parameter int STAGE_MODULE = FHE_ALU_PKG::STAGE_MODULE,
  parameter int LEN_W        = FHE_ALU_PKG::SCHED_LEN_W,
  localparam int SW          = $clog2(SLOT_NUM)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [MODULE_NUM-1:0]            req_valid,
  input  logic [MODULE_NUM-1:0][SW-1:0]    req_slot,
  input  logic [MODULE_NUM-1:0][LEN_W-1:0] req_len,
  output logic [MODULE_NUM-1:0]            req_grant,
  output logic [MODULE_NUM-1:0]            mod_busy,
  output logic [MODULE_NUM-1:0]            mod_done,
  output logic [MODULE_NUM-1:0][SW-1:0]    module_select,
  output logic [MODULE_NUM-1:0][SW-1:0]    slot_select
);

  logic [MODULE_NUM-1:0][MODULE_NUM-1:0] elig;
  logic [MODULE_NUM-1:0]                 slot_gv, slot_busy, slot_last, slot_act;
  logic [MODULE_NUM-1:0][SW-1:0]         slot_gm, slot_own;
  logic [MODULE_NUM-1:0]                 active_m, busy_m, done_m;
  logic [MODULE_NUM-1:0]                 grant_q, grant_d;
  logic [MODULE_NUM-1:0][SW-1:0]         msel_q, msel_d, ssel_q, ssel_d;

  for (genvar s = 0; s < MODULE_NUM; s++) begin : g_slot
    slot_owner_fsm #(
      .N_MOD(MODULE_NUM), .SW(SW), .STAGE(STAGE_MODULE), .LEN_W(LEN_W)
    ) u_fsm (
      .clk        (clk),
      .rstn       (rstn),
      .elig       (elig[s]),
      .req_len    (req_len),
      .grant_valid(slot_gv[s]),
      .grant_mod  (slot_gm[s]),
      .busy       (slot_busy[s]),
      .drain_last (slot_last[s]),
      .active     (slot_act[s]),
      .owner      (slot_own[s])
    );
  end

  // Fan slot ownership state back onto the modules that own them
  always_comb begin
    active_m = '0;
    busy_m   = '0;
    done_m   = '0;
    for (int s = 0; s < MODULE_NUM; s++) begin
      for (int m = 0; m < MODULE_NUM; m++) begin
        active_m[m] = active_m[m] | (slot_act[s]  & (slot_own[s] == SW'(m)));
        busy_m[m]   = busy_m[m]   | (slot_busy[s] & (slot_own[s] == SW'(m)));
        done_m[m]   = done_m[m]   | (slot_last[s] & (slot_own[s] == SW'(m)));
      end
    end
  end

  // Slot indices >= MODULE_NUM match no slot row and are silently dropped
  always_comb begin
    elig = '0;
    for (int s = 0; s < MODULE_NUM; s++) begin
      for (int m = 0; m < MODULE_NUM; m++) begin
        elig[s][m] = req_valid[m] & (req_slot[m] == SW'(s)) & ~active_m[m];
      end
    end
  end

  // Grant pulses and select updates; selects hold until the next grant
  always_comb begin
    grant_d = '0;
    msel_d  = msel_q;
    ssel_d  = ssel_q;
    for (int s = 0; s < MODULE_NUM; s++) begin
      msel_d[s] = slot_gv[s] ? slot_gm[s] : msel_q[s];
      for (int m = 0; m < MODULE_NUM; m++) begin
        grant_d[m] = grant_d[m] | (slot_gv[s] & (slot_gm[s] == SW'(m)));
        ssel_d[m]  = (slot_gv[s] && (slot_gm[s] == SW'(m))) ? SW'(s) : ssel_d[m];
      end
    end
  end

  // Output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      grant_q <= '0;
      msel_q  <= '0;
      ssel_q  <= '0;
    end else begin
      grant_q <= grant_d;
      msel_q  <= msel_d;
      ssel_q  <= ssel_d;
    end
  end

  assign req_grant     = grant_q;
  assign mod_busy      = busy_m;
  assign mod_done      = done_m;
  assign module_select = msel_q;
  assign slot_select   = ssel_q;

endmodule

// File: tb/tb_interconnect_scheduler.sv
// Directed self-checking bench for interconnect_scheduler.
// SLOT_NUM=8 gives a 3-bit slot index so an out-of-range slot (5) is representable.
module tb_interconnect_scheduler;

  localparam int M  = 4;
  localparam int SW = 3;

  logic                clk = 1'b0;
  logic                rstn;
  logic [M-1:0]        req_valid;
  logic [M-1:0][SW-1:0] req_slot;
  logic [M-1:0][15:0]  req_len;
  logic [M-1:0]        req_grant, mod_busy, mod_done;
  logic [M-1:0][SW-1:0] module_select, slot_select;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  interconnect_scheduler #(
    .MODULE_NUM(4), .SLOT_NUM(8), .STAGE_MODULE(2), .LEN_W(16)
  ) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_slot(req_slot), .req_len(req_len),
    .req_grant(req_grant), .mod_busy(mod_busy), .mod_done(mod_done),
    .module_select(module_select), .slot_select(slot_select)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_slot  = '0;
    req_len   = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear_reqs();
    tick();
    tick();
    checks++;
    if ({req_grant, mod_busy, mod_done} !== 12'h000) begin
      errors++;
      $display("FAIL reset_flags got=%h exp=000", {req_grant, mod_busy, mod_done});
    end
    checks++;
    if ({module_select, slot_select} !== 24'h0) begin
      errors++;
      $display("FAIL reset_selects got=%h exp=0", {module_select, slot_select});
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [3:0] eb, ed;
    req_valid[1] = 1'b1; req_slot[1] = 3'd2; req_len[1] = 16'd3;
    tick();  // t+1
    checks++;
    if (req_grant !== 4'b0010 || mod_busy !== 4'b0010) begin
      errors++;
      $display("FAIL single_grant got grant=%b busy=%b exp 0010/0010", req_grant, mod_busy);
    end
    checks++;
    if (module_select[2] !== 3'd1 || slot_select[1] !== 3'd2) begin
      errors++;
      $display("FAIL single_sel got msel2=%0d ssel1=%0d exp 1/2", module_select[2], slot_select[1]);
    end
    req_valid[1] = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      eb = (c <= 3) ? 4'b0010 : 4'b0000;
      ed = (c == 5) ? 4'b0010 : 4'b0000;
      checks++;
      if ({req_grant, mod_busy, mod_done} !== {4'b0000, eb, ed}) begin
        errors++;
        $display("FAIL single_cyc%0d got=%b exp=%b", c, {req_grant, mod_busy, mod_done}, {4'b0000, eb, ed});
      end
    end
    // request placed in the done cycle wins the very next cycle
    req_valid[0] = 1'b1; req_slot[0] = 3'd2; req_len[0] = 16'd1;
    tick();
    checks++;
    if (req_grant !== 4'b0001 || module_select[2] !== 3'd0 || slot_select[1] !== 3'd2) begin
      errors++;
      $display("FAIL single_regrant got grant=%b msel2=%0d ssel1=%0d exp 0001/0/2",
               req_grant, module_select[2], slot_select[1]);
    end
    req_valid[0] = 1'b0;
    tick();
    tick();
    checks++;
    if (mod_done !== 4'b0001) begin
      errors++;
      $display("FAIL single_regrant_done got=%b exp=0001", mod_done);
    end
    tick();
  endtask

  task automatic test_contention();
    int n = 0;
    int gwin[3];
    int gcyc[3];
    int ewin[3] = '{0, 2, 3};
    int ecyc[3] = '{1, 4, 7};
    for (int m = 0; m < M; m++) begin
      req_slot[m] = 3'd0; req_len[m] = 16'd1;
    end
    req_valid = 4'b1101;
    for (int c = 1; c <= 12; c++) begin
      tick();
      for (int m = 0; m < M; m++) begin
        if (req_grant[m]) begin
          if (n < 3) begin
            gwin[n] = m;
            gcyc[n] = c;
          end
          n++;
          req_valid[m] = 1'b0;
        end
      end
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL contention_count got=%0d exp=3", n);
    end
    for (int i = 0; i < 3 && i < n; i++) begin
      checks++;
      if (gwin[i] !== ewin[i] || gcyc[i] !== ecyc[i]) begin
        errors++;
        $display("FAIL contention_grant%0d got m%0d@%0d exp m%0d@%0d", i, gwin[i], gcyc[i], ewin[i], ecyc[i]);
      end
    end
    // rr[0] back at 0: m1 beats m3
    req_valid = 4'b1010;
    tick();
    checks++;
    if (req_grant !== 4'b0010) begin
      errors++;
      $display("FAIL contention_rr_wrap got=%b exp=0010", req_grant);
    end
    req_valid[1] = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (req_grant !== 4'b1000) begin
      errors++;
      $display("FAIL contention_m3_after got=%b exp=1000", req_grant);
    end
    req_valid = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_parallel();
    req_valid = 4'b1001;
    req_slot[0] = 3'd1; req_len[0] = 16'd2;
    req_slot[3] = 3'd2; req_len[3] = 16'd2;
    tick();
    checks++;
    if (req_grant !== 4'b1001 || mod_busy !== 4'b1001) begin
      errors++;
      $display("FAIL parallel_grant got grant=%b busy=%b exp 1001/1001", req_grant, mod_busy);
    end
    checks++;
    if (module_select[1] !== 3'd0 || module_select[2] !== 3'd3 ||
        slot_select[0] !== 3'd1 || slot_select[3] !== 3'd2) begin
      errors++;
      $display("FAIL parallel_sel got msel1=%0d msel2=%0d ssel0=%0d ssel3=%0d exp 0/3/1/2",
               module_select[1], module_select[2], slot_select[0], slot_select[3]);
    end
    req_valid = '0;
    tick();
    tick();
    tick();
    checks++;
    if (mod_done !== 4'b1001 || mod_busy !== 4'b0000) begin
      errors++;
      $display("FAIL parallel_done got done=%b busy=%b exp 1001/0000", mod_done, mod_busy);
    end
    tick();
  endtask

  task automatic test_busy_requester();
    logic [3:0] eg, ed;
    req_valid[1] = 1'b1; req_slot[1] = 3'd0; req_len[1] = 16'd2;
    tick();
    checks++;
    if (req_grant !== 4'b0010) begin
      errors++;
      $display("FAIL busyreq_first got=%b exp=0010", req_grant);
    end
    req_slot[1] = 3'd3; req_len[1] = 16'd1;
    for (int c = 2; c <= 5; c++) begin
      tick();
      eg = (c == 5) ? 4'b0010 : 4'b0000;
      ed = (c == 4) ? 4'b0010 : 4'b0000;
      checks++;
      if ({req_grant, mod_done} !== {eg, ed}) begin
        errors++;
        $display("FAIL busyreq_cyc%0d got=%b exp=%b", c, {req_grant, mod_done}, {eg, ed});
      end
    end
    checks++;
    if (slot_select[1] !== 3'd3 || module_select[3] !== 3'd1) begin
      errors++;
      $display("FAIL busyreq_sel got ssel1=%0d msel3=%0d exp 3/1", slot_select[1], module_select[3]);
    end
    req_valid = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_edges();
    req_valid[2] = 1'b1; req_slot[2] = 3'd3; req_len[2] = 16'd0;
    tick();
    checks++;
    if (req_grant !== 4'b0100 || mod_busy !== 4'b0100 || module_select[3] !== 3'd2) begin
      errors++;
      $display("FAIL len0_grant got grant=%b busy=%b msel3=%0d exp 0100/0100/2",
               req_grant, mod_busy, module_select[3]);
    end
    req_valid = '0;
    tick();
    checks++;
    if (mod_busy !== 4'b0000 || mod_done !== 4'b0000) begin
      errors++;
      $display("FAIL len0_drain got busy=%b done=%b exp 0000/0000", mod_busy, mod_done);
    end
    tick();
    checks++;
    if (mod_done !== 4'b0100) begin
      errors++;
      $display("FAIL len0_done got=%b exp=0100", mod_done);
    end
    tick();
    req_valid[0] = 1'b1; req_slot[0] = 3'd5; req_len[0] = 16'd3;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if ({req_grant, mod_busy, mod_done} !== 12'h000 || slot_select[0] !== 3'd1) begin
        errors++;
        $display("FAIL badslot_cyc%0d got flags=%h ssel0=%0d exp 000/1",
                 c, {req_grant, mod_busy, mod_done}, slot_select[0]);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid[3] = 1'b1; req_slot[3] = 3'd1; req_len[3] = 16'd8;
    tick();
    checks++;
    if (req_grant !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_grant got=%b exp=1000", req_grant);
    end
    req_valid = '0;
    tick();
    tick();
    checks++;
    if (mod_busy !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_busy got=%b exp=1000", mod_busy);
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checks++;
    if ({req_grant, mod_busy, mod_done} !== 12'h000 || {module_select, slot_select} !== 24'h0) begin
      errors++;
      $display("FAIL rstmid_outputs got flags=%h sel=%h exp 0/0",
               {req_grant, mod_busy, mod_done}, {module_select, slot_select});
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if ({mod_busy, mod_done} !== 8'h00) begin
        errors++;
        $display("FAIL rstmid_quiet_cyc%0d got=%h exp=00", c, {mod_busy, mod_done});
      end
    end
    req_valid[2] = 1'b1; req_slot[2] = 3'd1; req_len[2] = 16'd1;
    tick();
    checks++;
    if (req_grant !== 4'b0100 || module_select[1] !== 3'd2) begin
      errors++;
      $display("FAIL rstmid_fresh got grant=%b msel1=%0d exp 0100/2", req_grant, module_select[1]);
    end
    req_valid = '0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_parallel();
    test_busy_requester();
    test_edges();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
